// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-fed UART transmitter.
//   state_t      : transmitter FSM states (3-bit encoding, fixed values so the
//                  encoding is identical with and without the parity option)
//   DATA_BITS    : payload bits per frame
//   BIT_IDX_W    : width of the data-bit index
//   frame_bits() : number of bit cells per frame (10 for 8N1, 11 with parity)
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds an even-parity cell).
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  // Start + data + (parity) + stop.
  function automatic int frame_bits();
`ifdef FIFO_UART_TX_PARITY_EN
    return 1 + DATA_BITS + 1 + 1;
`else
    return 1 + DATA_BITS + 1;
`endif
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and pulses bit_done on the
// cycle the count equals CLKS_PER_BIT-1, then wraps to 0 on its own so
// consecutive bit cells follow without a gap.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   clr      : hold the counter at 0 (used while no bit cell is running)
//   bit_done : single-cycle pulse on the last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign bit_done = !clr && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Read-side consumer of an 8-deep byte FIFO: pops one byte at a time and
// sends it LSB first as an 8N1 UART frame (8E1 when FIFO_UART_TX_PARITY_EN
// is defined: an even-parity cell is inserted between the data and stop).
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset (aborts a frame in flight)
//   tx_en      : permission to start new frames; a running frame completes
//   fifo_empty : FIFO empty flag
//   fifo_dout  : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    : FIFO read strobe, one-cycle pulse (decode of REQ)
//   tx         : serial line, idle high, driven from a register
//   busy       : high from REQ through the end of STOP
//   frame_cnt  : completed frames, wraps modulo 2^CNT_W
// Internal debug: `state` holds the current FSM state (state_t).
// ---------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  state_t               state, state_n;
  logic [7:0]           shift, shift_n;
  logic [BIT_IDX_W-1:0] bit_idx, bit_idx_n;
  logic                 tx_n;
  logic                 cnt_inc;
  logic                 baud_clr;
  logic                 bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 parity;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  // FIFO read handshake: the FIFO is only read from REQ, which is entered
  // only from IDLE when tx_en=1 and fifo_empty=0; fifo_rd is a one-cycle
  // pulse and the byte is taken from fifo_dout in LOAD, the following
  // cycle. Once REQ is entered the read is committed and the frame is sent
  // regardless of tx_en. The next read cannot happen before the current
  // frame's STOP cell has finished, so reads never outpace the line.
  assign fifo_rd = (state == REQ);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
      frame_cnt <= '0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
      if (cnt_inc) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Parity is latched at LOAD because the shift register is consumed
  // by the time the parity cell is sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (state == LOAD) begin
      parity <= ^fifo_dout;
    end
  end
`endif

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    baud_clr  = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        baud_clr = 1'b1;
        if (tx_en && !fifo_empty) begin
          state_n = REQ;
        end
      end
      REQ: begin
        baud_clr = 1'b1;
        state_n  = LOAD;
      end
      LOAD: begin
        baud_clr = 1'b1;
        shift_n  = fifo_dout;
        state_n  = START;
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + BIT_IDX_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_n = IDLE;
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The line level is computed from the *next* state and shift contents and
  // registered, so tx changes exactly on the state transition and never
  // glitches.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_n = parity;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4. A small FIFO model
// feeds the DUT; frames are decoded from tx by sampling every cycle.
// Build with FIFO_UART_TX_PARITY_EN to exercise the parity cell.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB      = 11;
  localparam int SPACING = 47;
`else
  localparam int NB      = 10;
  localparam int SPACING = 43;
`endif

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_rd;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model and monitors ----------------
  logic [7:0] fifo_mem [8];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_empty_cnt = 0;
  int last_rd_cyc = 0;
  int prev_rd_cyc = 0;
  logic [7:0] exp_q[$];
  int exp_frames = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  initial fifo_dout = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      rd_cnt      <= rd_cnt + 1;
      prev_rd_cyc <= last_rd_cyc;
      last_rd_cyc <= cyc;
      if (fifo_empty) begin
        rd_empty_cnt <= rd_empty_cnt + 1;
      end else begin
        fifo_dout <= fifo_mem[rd_ptr % 8];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr % 8] = b;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  task automatic wait_start(output int sc, output bit ok);
    ok = 1'b0;
    sc = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        sc = cyc;
      end
    end
  endtask

  // Returns at the negedge of the last cycle of the stop cell.
  task automatic recv_frame(output logic [10:0] fb, output bit glitch,
                            output int sc, output bit ok);
    fb = '1;
    glitch = 1'b0;
    wait_start(sc, ok);
    if (ok) begin
      for (int b = 0; b < NB; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (c == 0) fb[b] = tx;
          else if (tx !== fb[b]) glitch = 1'b1;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 4;
      if (tx !== 1'b1) begin
        failures++; $display("FAIL reset_tx cyc%0d got=%b exp=1", i, tx);
      end
      if (fifo_rd !== 1'b0) begin
        failures++; $display("FAIL reset_rd cyc%0d got=%b exp=0", i, fifo_rd);
      end
      if (busy !== 1'b0) begin
        failures++; $display("FAIL reset_busy cyc%0d got=%b exp=0", i, busy);
      end
      if (frame_cnt !== 16'd0) begin
        failures++; $display("FAIL reset_cnt cyc%0d got=%0d exp=0", i, frame_cnt);
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_rd !== 1'b0 || rd_cnt != 0) begin
      failures++; $display("FAIL idle_empty_rd got=%0d exp=0", rd_cnt);
    end
  endtask

  task automatic test_single();
    logic [10:0] fb;
    bit glitch, ok;
    int sc, rd0;
    logic [7:0] exp;
    rd0 = rd_cnt;
    tx_en = 1'b1;
    push_byte(8'hA5);
    recv_frame(fb, glitch, sc, ok);
    exp = exp_q.pop_front();
    checks += 5;
    if (!ok) begin
      failures++; $display("FAIL single_start got=timeout exp=start");
    end
    if (glitch) begin
      failures++; $display("FAIL single_hold got=glitch exp=4-cycle cells");
    end
    if (fb[0] !== 1'b0 || fb[NB-1] !== 1'b1) begin
      failures++; $display("FAIL single_framing got=%b/%b exp=0/1", fb[0], fb[NB-1]);
    end
    if (fb[8:1] !== exp) begin
      failures++; $display("FAIL single_data got=%h exp=%h", fb[8:1], exp);
    end
    if (sc - last_rd_cyc != 2) begin
      failures++; $display("FAIL single_latency got=%0d exp=2", sc - last_rd_cyc);
    end
    @(negedge clk);
    exp_frames++;
    repeat (5) @(negedge clk);
    checks += 3;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL single_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
    end
    if (rd_cnt - rd0 != 1) begin
      failures++; $display("FAIL single_rd got=%0d exp=1", rd_cnt - rd0);
    end
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++; $display("FAIL single_idle got=busy%b tx%b exp=busy0 tx1", busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fb;
    bit glitch, ok;
    int sc, prev_sc, rd0;
    logic [7:0] exp;
    rd0 = rd_cnt;
    prev_sc = 0;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    for (int k = 0; k < 3; k++) begin
      recv_frame(fb, glitch, sc, ok);
      exp = exp_q.pop_front();
      checks += 2;
      if (!ok || glitch || fb[0] !== 1'b0 || fb[NB-1] !== 1'b1) begin
        failures++; $display("FAIL b2b_frame%0d got=ok%0d glitch%0d exp=ok1 glitch0", k, ok, glitch);
      end
      if (fb[8:1] !== exp) begin
        failures++; $display("FAIL b2b_data%0d got=%h exp=%h", k, fb[8:1], exp);
      end
      if (k > 0) begin
        checks += 2;
        if (sc - prev_sc != SPACING) begin
          failures++; $display("FAIL b2b_start_gap%0d got=%0d exp=%0d", k, sc - prev_sc, SPACING);
        end
        if (last_rd_cyc - prev_rd_cyc != SPACING) begin
          failures++; $display("FAIL b2b_rd_gap%0d got=%0d exp=%0d", k, last_rd_cyc - prev_rd_cyc, SPACING);
        end
      end
      prev_sc = sc;
      exp_frames++;
    end
    repeat (30) @(negedge clk);
    checks += 2;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
    end
    if (rd_cnt - rd0 != 3 || rd_empty_cnt != 0) begin
      failures++; $display("FAIL b2b_rd got=%0d/%0d exp=3/0", rd_cnt - rd0, rd_empty_cnt);
    end
  endtask

  task automatic test_tx_en_gating();
    logic [10:0] fb;
    bit glitch, ok;
    int sc, rd0;
    logic [7:0] exp;
    rd0 = rd_cnt;
    tx_en = 1'b1;
    push_byte(8'h55);
    push_byte(8'h81);
    fork
      recv_frame(fb, glitch, sc, ok);
      begin
        repeat (13) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    exp = exp_q.pop_front();
    checks++;
    if (!ok || glitch || fb[8:1] !== exp || fb[NB-1] !== 1'b1) begin
      failures++; $display("FAIL gate_frame got=%h ok%0d exp=%h", fb[8:1], ok, exp);
    end
    @(negedge clk);
    exp_frames++;
    repeat (30) @(negedge clk);
    checks += 3;
    if (rd_cnt - rd0 != 1) begin
      failures++; $display("FAIL gate_hold_rd got=%0d exp=1", rd_cnt - rd0);
    end
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++; $display("FAIL gate_hold_idle got=busy%b tx%b exp=busy0 tx1", busy, tx);
    end
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL gate_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
    end
    tx_en = 1'b1;
    recv_frame(fb, glitch, sc, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || glitch || fb[8:1] !== exp) begin
      failures++; $display("FAIL gate_resume got=%h ok%0d exp=%h", fb[8:1], ok, exp);
    end
    @(negedge clk);
    exp_frames++;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] fb;
    bit glitch, ok;
    int sc, rd0;
    logic [7:0] exp;
    rd0 = rd_cnt;
    tx_en = 1'b1;
    push_byte(8'hC3);
    push_byte(8'h5A);
    void'(exp_q.pop_front());
    wait_start(sc, ok);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL midrst_tx got=%b exp=1", tx);
    end
    if (frame_cnt !== 16'd0) begin
      failures++; $display("FAIL midrst_cnt got=%0d exp=0", frame_cnt);
    end
    if (busy !== 1'b0 || fifo_rd !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got=busy%b rd%b exp=0/0", busy, fifo_rd);
    end
    exp_frames = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    recv_frame(fb, glitch, sc, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || glitch || fb[8:1] !== exp || fb[0] !== 1'b0 || fb[NB-1] !== 1'b1) begin
      failures++; $display("FAIL midrst_next got=%h ok%0d exp=%h", fb[8:1], ok, exp);
    end
    @(negedge clk);
    exp_frames++;
    repeat (3) @(negedge clk);
    checks += 2;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL midrst_cnt_after got=%0d exp=%0d", frame_cnt, exp_frames);
    end
    if (rd_cnt - rd0 != 2) begin
      failures++; $display("FAIL midrst_rd got=%0d exp=2", rd_cnt - rd0);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] fb;
    bit glitch, ok;
    int sc, prev_sc;
    logic [7:0] exp;
    logic exp_par [2];
    exp_par[0] = 1'b1;
    exp_par[1] = 1'b0;
    prev_sc = 0;
    tx_en = 1'b1;
    push_byte(8'h07);
    push_byte(8'h03);
    for (int k = 0; k < 2; k++) begin
      recv_frame(fb, glitch, sc, ok);
      exp = exp_q.pop_front();
      checks += 2;
      if (!ok || glitch || fb[8:1] !== exp || fb[10] !== 1'b1) begin
        failures++; $display("FAIL par_frame%0d got=%h exp=%h", k, fb[8:1], exp);
      end
      if (fb[9] !== exp_par[k]) begin
        failures++; $display("FAIL par_bit%0d got=%b exp=%b", k, fb[9], exp_par[k]);
      end
      if (k > 0) begin
        checks++;
        if (sc - prev_sc != 47) begin
          failures++; $display("FAIL par_gap got=%0d exp=47", sc - prev_sc);
        end
      end
      prev_sc = sc;
      exp_frames++;
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    tx_en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_tx_en_gating();
    test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (rd_empty_cnt != 0) begin
      failures++; $display("FAIL rd_while_empty got=%0d exp=0", rd_empty_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's 8-deep byte FIFO.
- Pops one byte at a time through the FIFO read port (rd/empty/dout, one-cycle read latency) and transmits it as an 8N1 UART frame on a serial line, LSB first.
- Sits between the FIFO and the board TX pin; handles all FIFO read handshaking so the FIFO is never read while empty and never read faster than bytes can be sent.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (legal range 2..65535).
- CNT_W, 16, width of the frames-sent counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tx_en  input  1  permission to start new frames; a frame in flight always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO read data, valid the cycle after fifo_rd.
- fifo_rd  output  1  FIFO read strobe, single-cycle pulse.
- tx  output  1  serial line; idle high.
- busy  output  1  high from the REQ state through the end of STOP.
- frame_cnt  output  CNT_W  count of completed frames; wraps to 0.

Behaviour:
- Reset (async, rst=1) forces: state=IDLE, tx=1, fifo_rd=0, busy=0, frame_cnt=0, shift register=0, bit/baud counters=0. Takes effect immediately, including mid-frame; a partially sent byte is lost and not re-read.
- fifo_rd is a decode of state==REQ; it is never asserted in any other state and never while fifo_empty=1.
- IDLE: tx=1.
  - If tx_en && !fifo_empty, go to REQ; otherwise stay.
- REQ (1 cycle): fifo_rd=1, go to LOAD.
- LOAD (1 cycle): capture fifo_dout into the 8-bit shift register, clear the baud counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit end. After bit index 7, go to STOP (or PARITY, see Optional Feature).
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle, frame_cnt increments (modulo 2^CNT_W) and the state returns to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; a bit period ends on the cycle the counter equals CLKS_PER_BIT-1.
- Latency:
  - fifo_rd asserts 1 cycle after IDLE sees !fifo_empty.
  - tx falls 2 cycles after the fifo_rd cycle.
- Back-to-back frames (FIFO non-empty, tx_en=1): start-bit edges are spaced 10*CLKS_PER_BIT+3 cycles apart (1 IDLE, 1 REQ, 1 LOAD).
- tx_en dropped mid-frame: the current frame completes, then the block holds in IDLE.
- tx_en dropped during REQ or LOAD: the read already committed, so the frame is sent.
- fifo_empty rising during STOP: the block returns to IDLE and waits; no read is issued.
- tx is driven from a register, so it is glitch-free.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent in a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles. The frame is 11 bits and back-to-back spacing is 11*CLKS_PER_BIT+3 cycles.
- Undefined: no PARITY state exists; 8N1 framing as above.

Decomposition:
- Package fifo_uart_pkg:
  - state typedef enum {IDLE, REQ, LOAD, START, DATA, PARITY, STOP}, 3-bit encoding.
  - DATA_BITS=8 constant.
  - Function for the frame bit count (10 or 11 depending on the macro).
- One sub-module, uart_baud_cnt: parameterised by CLKS_PER_BIT; inputs clk, rst, clr; output bit_done pulse.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset idle: hold rst 3 cycles with fifo_empty=1 -> tx=1, fifo_rd=0, busy=0, frame_cnt=0 throughout; no fifo_rd while empty.
- Single byte: fifo_dout=0xA5 presented after one fifo_rd pulse -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame_cnt=1; exactly one fifo_rd.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C -> three fifo_rd pulses 43 cycles apart; bytes decoded in order; frame_cnt=3; no fifo_rd after empty asserts.
- tx_en gating: deassert tx_en 10 cycles into the frame for 0x55 -> frame completes, then no fifo_rd until tx_en=1 again.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 in the same cycle, frame_cnt=0; after release with the FIFO non-empty, a new read and a full frame follow.
- Parity (macro defined): byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; start-edge spacing 47 cycles.
